// File: rtl/i2c_frame_counter.sv
// I2C subordinate bit/byte frame tracker, advanced on posedge scl.
// Optional 10-bit address extension of addr_phase: define I2C_CNT_ADDR10_EN.
module i2c_frame_counter #(
  parameter  int DATA_BITS = 8,
  parameter  int MAX_BYTES = 16,
  localparam int BIT_W     = $clog2(DATA_BITS + 1),
  localparam int BYTE_W    = $clog2(MAX_BYTES)
) (
  input  logic                 scl,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 sda_in,
  output logic                 active,
  output logic [BIT_W-1:0]     bit_idx,
  output logic                 ack_phase,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  output logic [BYTE_W-1:0]    byte_cnt,
  output logic                 addr_phase,
  output logic                 overflow
);

  localparam int SW = DATA_BITS - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_active;
  logic [BIT_W-1:0]       r_bit_idx;
  logic                   r_ack;
  logic [SW-1:0]          r_shift;
  logic [DATA_BITS-1:0]   r_rx_byte;
  logic                   r_rx_valid;
  logic [BYTE_W-1:0]      r_byte_cnt;
  logic                   r_overflow;

  logic [DATA_BITS-1:0]   w_next;
  logic                   w_lsb;
  logic                   w_cnt_max;

  assign w_next    = {r_shift, sda_in};
  // bit_idx holds the slot already sampled, so the LSB arrives one after DATA_BITS-2
  assign w_lsb     = (r_bit_idx == BIT_W'(DATA_BITS - 2));
  assign w_cnt_max = (r_byte_cnt == BYTE_W'(MAX_BYTES - 1));

  always_ff @(posedge scl or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_active   <= 1'b0;
      r_bit_idx  <= '0;
      r_ack      <= 1'b0;
      r_shift    <= '0;
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
      r_byte_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (start) begin
      r_state    <= DATA;
      r_active   <= 1'b1;
      r_bit_idx  <= '0;
      r_ack      <= 1'b0;
      r_rx_valid <= 1'b0;
      r_shift    <= SW'(sda_in);
      r_byte_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (stop) begin
      r_state    <= IDLE;
      r_active   <= 1'b0;
      r_bit_idx  <= '0;
      r_ack      <= 1'b0;
      r_rx_valid <= 1'b0;
      r_byte_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: ;
        DATA: begin
          if (w_lsb) begin
            r_state    <= ACK;
            r_bit_idx  <= BIT_W'(DATA_BITS);
            r_ack      <= 1'b1;
            r_rx_valid <= 1'b1;
            r_rx_byte  <= w_next;
          end else begin
            r_bit_idx  <= r_bit_idx + 1'b1;
            r_shift    <= w_next[SW-1:0];
          end
        end
        ACK: begin
          r_state    <= DATA;
          r_bit_idx  <= '0;
          r_ack      <= 1'b0;
          r_rx_valid <= 1'b0;
          r_shift    <= SW'(sda_in);
          if (w_cnt_max) r_overflow <= 1'b1;
          else           r_byte_cnt <= r_byte_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef I2C_CNT_ADDR10_EN
  if (DATA_BITS != 8) begin : g_addr10_chk
    $error("I2C_CNT_ADDR10_EN requires DATA_BITS == 8");
  end

  logic r_addr10;

  // 10-bit header 11110xx? seen in byte 0 keeps byte 1 in the address phase
  always_ff @(posedge scl or negedge rst) begin
    if (!rst) begin
      r_addr10 <= 1'b0;
    end else if (start || stop) begin
      r_addr10 <= 1'b0;
    end else if (r_state == DATA && w_lsb && r_byte_cnt == '0) begin
      r_addr10 <= (w_next[DATA_BITS-1 -: 5] == 5'b11110);
    end
  end

  assign addr_phase = r_active &&
    (r_byte_cnt == '0 || (r_addr10 && r_byte_cnt == BYTE_W'(1)));
`else
  assign addr_phase = r_active && (r_byte_cnt == '0);
`endif

  assign active    = r_active;
  assign bit_idx   = r_bit_idx;
  assign ack_phase = r_ack;
  assign rx_byte   = r_rx_byte;
  assign rx_valid  = r_rx_valid;
  assign byte_cnt  = r_byte_cnt;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_i2c_frame_counter.sv
// Bench for i2c_frame_counter: directed steps plus random traffic against
// a byte-level reference model; two instances (MAX_BYTES 16 and 4).
module tb_i2c_frame_counter;

`ifdef I2C_CNT_ADDR10_EN
  localparam bit ADDR10 = 1'b1;
`else
  localparam bit ADDR10 = 1'b0;
`endif
  localparam int DB = 8;

  logic scl = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic sda_in = 1'b0;

  logic       a_active, a_ack, a_valid, a_addr, a_ovf;
  logic [3:0] a_bit;
  logic [7:0] a_rx;
  logic [3:0] a_cnt;
  logic       b_active, b_ack, b_valid, b_addr, b_ovf;
  logic [3:0] b_bit;
  logic [7:0] b_rx;
  logic [1:0] b_cnt;

  i2c_frame_counter #(.DATA_BITS(8), .MAX_BYTES(16)) dut_a (
    .scl(scl), .rst(rst), .start(start), .stop(stop), .sda_in(sda_in),
    .active(a_active), .bit_idx(a_bit), .ack_phase(a_ack),
    .rx_byte(a_rx), .rx_valid(a_valid), .byte_cnt(a_cnt),
    .addr_phase(a_addr), .overflow(a_ovf)
  );

  i2c_frame_counter #(.DATA_BITS(8), .MAX_BYTES(4)) dut_b (
    .scl(scl), .rst(rst), .start(start), .stop(stop), .sda_in(sda_in),
    .active(b_active), .bit_idx(b_bit), .ack_phase(b_ack),
    .rx_byte(b_rx), .rx_valid(b_valid), .byte_cnt(b_cnt),
    .addr_phase(b_addr), .overflow(b_ovf)
  );

  always #5 scl = ~scl;

  int n_chk = 0;
  int n_pass = 0;

  // reference model: bits collected in current byte, bytes seen so far
  bit m_act, m_ack, m_valid, m_a10, m_ovf16, m_ovf4;
  int m_bits, m_val, m_rx, m_n;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_act = 0; m_ack = 0; m_valid = 0; m_a10 = 0;
    m_ovf16 = 0; m_ovf4 = 0;
    m_bits = 0; m_val = 0; m_rx = 0; m_n = 0;
  endtask

  task automatic model_edge(bit st, bit sp, bit d);
    m_valid = 0;
    if (st) begin
      m_act = 1; m_ack = 0; m_bits = 1; m_val = d; m_n = 0;
      m_a10 = 0; m_ovf16 = 0; m_ovf4 = 0;
    end else if (sp) begin
      m_act = 0; m_ack = 0; m_bits = 0; m_n = 0; m_a10 = 0;
    end else if (m_act && m_ack) begin
      m_ack = 0; m_bits = 1; m_val = d; m_n++;
      if (m_n >= 16) m_ovf16 = 1;
      if (m_n >= 4) m_ovf4 = 1;
    end else if (m_act) begin
      m_val = m_val * 2 + d;
      m_bits++;
      if (m_bits == DB) begin
        m_ack = 1; m_valid = 1; m_rx = m_val;
        if (m_n == 0) m_a10 = ((m_rx >> 3) == 'h1E);
      end
    end
  endtask

  task automatic check_all(string tag);
    int e_bit;
    bit e_addr;
    e_bit = m_ack ? DB : (m_act ? m_bits - 1 : 0);
    e_addr = m_act && (m_n == 0 || (ADDR10 && m_a10 && m_n == 1));
    chk({tag, " a.active"}, 32'(a_active), 32'(m_act));
    chk({tag, " a.bit_idx"}, 32'(a_bit), 32'(e_bit));
    chk({tag, " a.ack"}, 32'(a_ack), 32'(m_ack));
    chk({tag, " a.rx_byte"}, 32'(a_rx), 32'(m_rx));
    chk({tag, " a.rx_valid"}, 32'(a_valid), 32'(m_valid));
    chk({tag, " a.byte_cnt"}, 32'(a_cnt), 32'(m_n > 15 ? 15 : m_n));
    chk({tag, " a.addr"}, 32'(a_addr), 32'(e_addr));
    chk({tag, " a.ovf"}, 32'(a_ovf), 32'(m_ovf16));
    chk({tag, " b.bit_idx"}, 32'(b_bit), 32'(e_bit));
    chk({tag, " b.rx_valid"}, 32'(b_valid), 32'(m_valid));
    chk({tag, " b.byte_cnt"}, 32'(b_cnt), 32'(m_n > 3 ? 3 : m_n));
    chk({tag, " b.addr"}, 32'(b_addr), 32'(e_addr));
    chk({tag, " b.ovf"}, 32'(b_ovf), 32'(m_ovf4));
  endtask

  task automatic step(string tag, bit st, bit sp, bit d);
    @(negedge scl);
    start = st; stop = sp; sda_in = d;
    @(posedge scl);
    model_edge(st, sp, d);
    #1;
    check_all(tag);
  endtask

  task automatic send_byte(string tag, bit with_start, logic [7:0] b);
    for (int i = 0; i < 8; i++)
      step(tag, with_start && i == 0, 1'b0, b[7-i]);
  endtask

  initial begin
    model_reset();
    // T1: reset state, async reset mid-byte, idle hold
    #3;
    check_all("T1 por");
    @(negedge scl); rst = 1'b1;
    step("T1 start", 1, 0, 1);
    for (int i = 0; i < 4; i++) step("T1 bits", 0, 0, 1);
    chk("T1 bit4", 32'(a_bit), 32'd4);
    #2;
    rst = 1'b0; start = 0; stop = 0;
    #1;
    model_reset();
    check_all("T1 async");
    chk("T1 async active", 32'(a_active), 32'd0);
    @(negedge scl); rst = 1'b1;
    step("T1 idle", 0, 0, 1);
    step("T1 idle", 0, 0, 0);
    chk("T1 idle active", 32'(a_active), 32'd0);

    // T2: single byte A6
    send_byte("T2", 1, 8'hA6);
    chk("T2 rx_byte", 32'(a_rx), 32'hA6);
    chk("T2 rx_valid", 32'(a_valid), 32'd1);
    chk("T2 bit_idx", 32'(a_bit), 32'd8);
    chk("T2 ack", 32'(a_ack), 32'd1);
    step("T2 next", 0, 0, 0);
    chk("T2 next bit_idx", 32'(a_bit), 32'd0);
    chk("T2 next byte_cnt", 32'(a_cnt), 32'd1);

    // T3: three bytes then stop
    send_byte("T3", 1, 8'h3C);
    send_byte("T3", 0, 8'h81);
    send_byte("T3", 0, 8'h5E);
    chk("T3 byte_cnt2", 32'(a_cnt), 32'd2);
    chk("T3 addr byte2", 32'(a_addr), 32'd0);
    step("T3 stop", 0, 1, 1);
    chk("T3 stop active", 32'(a_active), 32'd0);
    chk("T3 stop rx hold", 32'(a_rx), 32'h5E);

    // T4: repeated start at bit_idx 5 of byte 2
    send_byte("T4", 1, 8'h12);
    send_byte("T4", 0, 8'h34);
    for (int i = 0; i < 6; i++) step("T4 part", 0, 0, 1);
    chk("T4 bit5", 32'(a_bit), 32'd5);
    step("T4 rstart", 1, 0, 0);
    chk("T4 bit_idx", 32'(a_bit), 32'd0);
    chk("T4 byte_cnt", 32'(a_cnt), 32'd0);
    chk("T4 addr", 32'(a_addr), 32'd1);

    // T5: six bytes on MAX_BYTES=4 instance
    send_byte("T5", 1, 8'h01);
    for (int k = 1; k < 6; k++) send_byte("T5", 0, 8'(k * 37));
    chk("T5 b.byte_cnt", 32'(b_cnt), 32'd3);
    chk("T5 b.ovf", 32'(b_ovf), 32'd1);
    step("T5 start", 1, 0, 1);
    chk("T5 b.ovf clear", 32'(b_ovf), 32'd0);

    // T6: start and stop together; 10-bit header handling
    step("T6 both", 1, 1, 1);
    chk("T6 active", 32'(a_active), 32'd1);
    chk("T6 bit_idx", 32'(a_bit), 32'd0);
    send_byte("T6 hdr", 1, 8'hF0);
    step("T6 b1", 0, 0, 1);
    chk("T6 addr byte1 F0", 32'(a_addr), 32'(ADDR10));
    for (int i = 0; i < 7; i++) step("T6 b1", 0, 0, 0);
    step("T6 b2", 0, 0, 0);
    chk("T6 addr byte2 F0", 32'(a_addr), 32'd0);
    send_byte("T6 hdrA0", 1, 8'hA0);
    step("T6 A0b1", 0, 0, 1);
    chk("T6 addr byte1 A0", 32'(a_addr), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 3) step("RND", 1, 0, 1'($urandom));
      else if (r < 5) step("RND", 0, 1, 1'($urandom));
      else if (r < 7) step("RND", 1, 1, 1'($urandom));
      else if (r < 9) send_byte("RND hdr", 1, {5'b11110, 3'($urandom)});
      else step("RND", 0, 0, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
